mem_access_unit: RTL

Load/store initiator between the MIPS execute stage and the word-wide, 512-entry data memory. It accepts one byte, halfword or word access at a time over a valid/ready request port. It drives the memory's separate write and read ports; reads are asynchronous and writes are clocked. Sub-word stores use an internal read-modify-write. Each completed access returns one response pulse carrying sign- or zero-extended load data.

---
 rtl/mem_access_pkg.sv | 27 ++
 rtl/mau_lane_align.sv | 39 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store initiator: access size encodings, FSM states and
// lane masks used by the alignment logic.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StMerge,
        StStore
    } state_e;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
    localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
    localparam logic [31:0] WORD_MASK = 32'hffff_ffff;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        return (size == SZ_ILLEGAL) ||
               ((size == SZ_HALF) && offset[0]) ||
               ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane logic: extracts and extends a little-endian load lane, and merges a
// right-justified store value into the old word for sub-word read-modify-write.
module mau_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] wr_data_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_word_o
);

    logic [4:0]  shamt;
    logic [15:0] lane;
    logic [31:0] mask;

    always_comb begin
        shamt = (size_i == SZ_HALF) ? {offset_i[1], 4'b0000} : {offset_i, 3'b000};
        lane  = 16'(rd_word_i >> shamt);
        case (size_i)
            SZ_BYTE: begin
                mask        = BYTE_MASK << shamt;
                load_data_o = {{24{signed_i & lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                mask        = HALF_MASK << shamt;
                load_data_o = {{16{signed_i & lane[15]}}, lane};
            end
            default: begin
                mask        = WORD_MASK;
                load_data_o = rd_word_i;
            end
        endcase
        merged_word_o = (rd_word_i & ~mask) | ((wr_data_i << shamt) & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between execute and a word-wide data memory; sub-word stores use RMW.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to reject misaligned/illegal accesses with resp_err.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [31:0]       mem_data_in
);

    localparam int unsigned AW = ADDR_W + 2;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic            signed_q, signed_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic            req_illegal;
    logic [1:0]      req_size_n;
    logic [AW-1:0]   req_addr_n;
    logic [31:0]     load_data;
    logic [31:0]     merged_word;
    logic            unused_addr_hi;

    // Byte address bits above the memory range wrap.
    assign unused_addr_hi = ^req_addr[31:AW];

    always_comb begin
        req_size_n = req_size;
        req_addr_n = req_addr[AW-1:0];
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        req_illegal = misaligned(req_size, req_addr[1:0]);
`else
        req_illegal = 1'b0;
        if (req_size == SZ_ILLEGAL) begin
            req_size_n = SZ_WORD;
        end
        if (req_size_n == SZ_HALF) begin
            req_addr_n[0] = 1'b0;
        end
        if (req_size_n == SZ_WORD) begin
            req_addr_n[1:0] = 2'b00;
        end
`endif
    end

    mau_lane_align u_lane_align (
        .rd_word_i     (mem_data_in),
        .wr_data_i     (wdata_q),
        .offset_i      (addr_q[1:0]),
        .size_i        (size_q),
        .signed_i      (signed_q),
        .load_data_o   (load_data),
        .merged_word_o (merged_word)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d   = req_addr_n;
                    size_d   = req_size_n;
                    signed_d = req_signed;
                    wdata_d  = req_wdata;
                    if (req_illegal) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_write) begin
                        state_d = StLoad;
                    end else if (req_size_n == SZ_WORD) begin
                        state_d = StStore;
                    end else begin
                        state_d = StMerge;
                    end
                end
            end
            StLoad: begin
                resp_rdata_d = load_data;
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            StMerge: begin
                wdata_d = merged_word;
                state_d = StStore;
            end
            StStore: begin
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready         = (state_q == StIdle) & ~rst;
    assign mem_we            = (state_q == StStore) & ~rst;
    assign mem_write_address = addr_q[AW-1:2];
    assign mem_write_data    = wdata_q;
    assign mem_read_address  = addr_q[AW-1:2];
    assign resp_valid        = resp_valid_q;
    assign resp_rdata        = resp_rdata_q;
    assign resp_err          = resp_err_q;

endmodule
